// File: rtl/finger_run_counter.sv
// Counts finger-width hand runs on one scan row above the latched palm; strobe lands one cycle after pixel (scan_row, hi).
// No backpressure: pixels are consumed whenever pix_valid is high, and state holds while it is low.
module finger_run_counter #(
    parameter int IMG_W         = 120,
    parameter int IMG_H         = 160,
    parameter int FINGER_OFFSET = 10,
    parameter int MARGIN        = 4,
    parameter int MIN_RUN       = 3,
    parameter int MAX_RUN       = 12,
    parameter int MAX_FINGERS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic       pix,
    input  logic [7:0] palm_r,
    input  logic [7:0] palm_c,
    input  logic [7:0] palm_w,
    input  logic       geom_valid,
    output logic [2:0] finger_count,
    output logic       count_valid,
    output logic       busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [9:0]    COL_LAST10 = 10'(IMG_W - 1);
    localparam logic [7:0]    OFS8       = 8'(FINGER_OFFSET);
    localparam logic [7:0]    MARGIN8    = 8'(MARGIN);
    localparam logic [7:0]    MIN8       = 8'(MIN_RUN);
    localparam logic [7:0]    MAX8       = 8'(MAX_RUN);
    localparam logic [2:0]    MAXF       = 3'(MAX_FINGERS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ROW,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [7:0]    r_scan_row;
    logic [7:0]    r_lo;
    logic [7:0]    r_hi;
    logic [7:0]    r_run;
    logic [2:0]    r_cnt;
    logic [2:0]    r_finger_count;
    logic          r_count_valid;
    logic          r_busy;

    logic          w_fs;
    logic [RW-1:0] w_cur_row;
    logic [CW-1:0] w_cur_col;
    logic [RW-1:0] w_nxt_row;
    logic [CW-1:0] w_nxt_col;
    logic [7:0]    w_cur_row8;
    logic [7:0]    w_cur_col8;

    logic [9:0]    w_hi_sum;
    logic [7:0]    w_new_row;
    logic [7:0]    w_new_lo;
    logic [7:0]    w_new_hi;
    logic [7:0]    w_row_sel;
    logic [7:0]    w_lo_sel;
    logic [7:0]    w_hi_sel;
    logic          w_at_start;
    logic          w_at_hi;
    logic          w_in_win;
    logic          w_take;

    logic [7:0]    w_run_base;
    logic [2:0]    w_cnt_base;
    logic [7:0]    w_run_inc;
    logic [7:0]    w_run_close;
    logic [2:0]    w_cnt_inc;
    logic          w_is_finger;
    logic          w_do_close;
    logic [7:0]    w_run_nxt;
    logic [2:0]    w_cnt_nxt;

    // A frame_start pixel is always position (0,0), whatever the counters say.
    assign w_fs       = pix_valid & frame_start;
    assign w_cur_row  = w_fs ? '0 : r_row;
    assign w_cur_col  = w_fs ? '0 : r_col;
    assign w_cur_row8 = 8'(w_cur_row);
    assign w_cur_col8 = 8'(w_cur_col);

    always_comb begin
        w_nxt_col = w_cur_col + CW'(1);
        w_nxt_row = w_cur_row;
        if (w_cur_col == COL_LAST) begin
            w_nxt_col = '0;
            w_nxt_row = (w_cur_row == ROW_LAST) ? '0 : w_cur_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (pix_valid) begin
            r_row <= w_nxt_row;
            r_col <= w_nxt_col;
        end
    end

    // Window edges are computed wide enough that palm_c + palm_w + MARGIN cannot wrap before clamping.
    assign w_hi_sum  = 10'(palm_c) + 10'(palm_w) + 10'(MARGIN);
    assign w_new_hi  = (w_hi_sum > COL_LAST10) ? 8'(IMG_W - 1) : w_hi_sum[7:0];
    assign w_new_row = (palm_r < OFS8)    ? 8'd0 : palm_r - OFS8;
    assign w_new_lo  = (palm_c < MARGIN8) ? 8'd0 : palm_c - MARGIN8;

    assign w_row_sel  = w_fs ? w_new_row : r_scan_row;
    assign w_lo_sel   = w_fs ? w_new_lo  : r_lo;
    assign w_hi_sel   = w_fs ? w_new_hi  : r_hi;
    assign w_at_start = (w_cur_row8 == w_row_sel) && (w_cur_col8 == w_lo_sel);
    assign w_at_hi    = (w_cur_col8 == w_hi_sel);
    assign w_in_win   = (w_cur_col8 >= r_lo);

    always_comb begin
        w_take = 1'b0;
        if (w_fs) begin
            w_take = geom_valid && w_at_start;
        end else if (pix_valid) begin
            w_take = ((r_state == ST_SCAN) && w_in_win) ||
                     ((r_state == ST_WAIT_ROW) && w_at_start);
        end
    end

    // The first window pixel always starts from a clean run and count.
    assign w_run_base = ((r_state == ST_SCAN) && !w_fs) ? r_run : 8'd0;
    assign w_cnt_base = ((r_state == ST_SCAN) && !w_fs) ? r_cnt : 3'd0;

    always_comb begin
        w_run_inc   = (w_run_base == 8'hFF) ? 8'hFF : w_run_base + 8'd1;
        w_run_close = pix ? w_run_inc : w_run_base;
        w_is_finger = (w_run_close >= MIN8) && (w_run_close <= MAX8);
        w_cnt_inc   = (w_cnt_base >= MAXF) ? MAXF : w_cnt_base + 3'd1;
        w_do_close  = w_at_hi || (!pix && (w_run_base != 8'd0));
        w_run_nxt   = w_do_close ? 8'd0 : w_run_close;
        w_cnt_nxt   = (w_do_close && w_is_finger) ? w_cnt_inc : w_cnt_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_scan_row     <= '0;
            r_lo           <= '0;
            r_hi           <= '0;
            r_run          <= '0;
            r_cnt          <= '0;
            r_finger_count <= '0;
            r_count_valid  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            if (w_fs && geom_valid) begin
                r_scan_row <= w_new_row;
                r_lo       <= w_new_lo;
                r_hi       <= w_new_hi;
            end
            if (w_take) begin
                r_run <= w_run_nxt;
                r_cnt <= w_cnt_nxt;
                if (w_at_hi) begin
                    r_state        <= ST_DONE;
                    r_busy         <= 1'b0;
                    r_count_valid  <= 1'b1;
                    r_finger_count <= w_cnt_nxt;
                end else begin
                    r_state <= ST_SCAN;
                    r_busy  <= 1'b1;
                end
            end else if (w_fs) begin
                // A new frame always aborts whatever was in flight, without a strobe.
                r_run <= '0;
                r_cnt <= '0;
                if (geom_valid) begin
                    r_state <= ST_WAIT_ROW;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign finger_count = r_finger_count;
    assign count_valid  = r_count_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_finger_run_counter.sv
// Directed bench for finger_run_counter: raster frames with a chosen scan row, expected counts queued per frame.
module tb_finger_run_counter;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       pix_valid;
    logic       pix;
    logic [7:0] palm_r;
    logic [7:0] palm_c;
    logic [7:0] palm_w;
    logic       geom_valid;
    logic [2:0] finger_count;
    logic       count_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int n_strobes = 0;
    int sb[$];
    logic [119:0] img;

    finger_run_counter dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix          (pix),
        .palm_r       (palm_r),
        .palm_c       (palm_c),
        .palm_w       (palm_w),
        .geom_valid   (geom_valid),
        .finger_count (finger_count),
        .count_valid  (count_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (count_valid === 1'b1) n_strobes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_run(input int a, input int b);
        for (int c = a; c <= b; c++) img[c] = 1'b1;
    endtask

    // One accepted pixel, optionally preceded by idle cycles carrying junk on frame_start/pix.
    task automatic drive_pix(input bit fs, input bit p, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                pix_valid   = 1'b0;
                frame_start = 1'($urandom);
                pix         = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        pix_valid   = 1'b1;
        frame_start = fs;
        pix         = p;
        @(posedge clk); #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Streams raster positions start_i .. start_i+n-1; scan row comes from img, other rows are noise.
    task automatic stream(input int pr, input int pc, input int pw, input bit gv,
                          input int start_i, input int n, input bit fs_first, input bit gaps);
        int srow;
        srow = (pr < 10) ? 0 : pr - 10;
        for (int i = start_i; i < start_i + n; i++) begin
            int r;
            int c;
            bit p;
            r = i / 120;
            c = i % 120;
            if (i == start_i) begin
                palm_r = 8'(pr); palm_c = 8'(pc); palm_w = 8'(pw); geom_valid = gv;
            end else begin
                palm_r = 8'($urandom); palm_c = 8'($urandom); palm_w = 8'($urandom);
                geom_valid = 1'($urandom);
            end
            p = (r == srow) ? img[c] : 1'($urandom);
            drive_pix(fs_first && (i == start_i), p, gaps);
        end
        geom_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int pr, input int pc, input int pw,
                             input int exp_cnt, input bit gaps);
        int srow;
        int hi;
        int s0;
        int k;
        int e;
        srow = (pr < 10) ? 0 : pr - 10;
        hi   = pc + pw + 4;
        if (hi > 119) hi = 119;
        sb.push_back(exp_cnt);
        s0 = n_strobes;
        stream(pr, pc, pw, 1'b1, 0, srow * 120 + hi + 1, 1'b1, gaps);
        check({tag, "_lat"}, 32'(count_valid), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        k = 0;
        while (count_valid !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        e = (sb.size() > 0) ? sb.pop_front() : -1;
        check({tag, "_cnt"}, 32'(finger_count), e);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(count_valid), 0);
        check({tag, "_hold"}, 32'(finger_count), e);
        check({tag, "_nstrobe"}, n_strobes - s0, 1);
    endtask

    initial begin
        int s0;
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix = 1'b0;
        palm_r = '0; palm_c = '0; palm_w = '0; geom_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", 32'(finger_count), 0);
        check("rst_vld", 32'(count_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        img = '0; add_run(40, 44); add_run(50, 53); add_run(60, 65);
        run_frame("t1", 60, 40, 30, 3, 1'b0);
        run_frame("t1gap", 60, 40, 30, 3, 1'b1);

        img = '0; add_run(40, 41); add_run(50, 64);
        run_frame("t2", 60, 40, 30, 0, 1'b0);

        img = '0; add_run(71, 80); add_run(30, 38);
        run_frame("t3", 60, 40, 30, 2, 1'b0);

        img = '0;
        for (int j = 0; j < 7; j++) add_run(37 + 5 * j, 40 + 5 * j);
        run_frame("t4sat", 60, 40, 30, 5, 1'b0);

        img = '0; add_run(40, 51); add_run(55, 67); add_run(70, 72);
        run_frame("t6edge", 60, 40, 30, 2, 1'b0);

        // Reset in the middle of the scan row.
        img = '0; add_run(40, 44); add_run(50, 53); add_run(60, 65);
        s0 = n_strobes;
        stream(60, 40, 30, 1'b1, 0, 50 * 120 + 55, 1'b1, 1'b0);
        check("rst_scan_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_scan_busy", 32'(busy), 0);
        check("rst_scan_cnt", 32'(finger_count), 0);
        check("rst_scan_vld", 32'(count_valid), 0);
        stream(60, 40, 30, 1'b1, 50 * 120 + 55, 40, 1'b0, 1'b0);
        check("rst_scan_nstrobe", n_strobes - s0, 0);
        check("rst_scan_busy_post", 32'(busy), 0);

        // Second frame_start arrives where pixel (30,5) would be.
        stream(60, 40, 30, 1'b1, 0, 30 * 120 + 5, 1'b1, 1'b0);
        check("abort_busy_pre", 32'(busy), 1);
        run_frame("abort", 60, 40, 30, 3, 1'b0);

        img = '0; add_run(0, 3); add_run(8, 11);
        run_frame("t5", 5, 2, 10, 2, 1'b0);

        stream(5, 2, 10, 1'b1, 0, 9, 1'b1, 1'b0);
        check("t5abort_busy_pre", 32'(busy), 1);
        run_frame("t5abort", 5, 2, 10, 2, 1'b0);

        s0 = n_strobes;
        stream(5, 2, 10, 1'b0, 0, 40, 1'b1, 1'b0);
        check("nogeom_busy", 32'(busy), 0);
        check("nogeom_nstrobe", n_strobes - s0, 0);
        check("nogeom_hold", 32'(finger_count), 2);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
